// File: rtl/net_bus_rx7_merge.sv
// Seven-to-one NetBus stream merger with per-packet round-robin grants.
// One registered output stage; SRC carries the origin port of each beat.
module net_bus_rx7_merge #(
    parameter int DATA_WIDTH = 4,
    parameter int LAST_BIT   = 0,
    parameter int PKT_LOCK   = 1,
    localparam int W         = DATA_WIDTH * 9 + 14
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] RDATA0,
    input  logic [W-1:0] RDATA1,
    input  logic [W-1:0] RDATA2,
    input  logic [W-1:0] RDATA3,
    input  logic [W-1:0] RDATA4,
    input  logic [W-1:0] RDATA5,
    input  logic [W-1:0] RDATA6,
    input  logic         RVALID0,
    input  logic         RVALID1,
    input  logic         RVALID2,
    input  logic         RVALID3,
    input  logic         RVALID4,
    input  logic         RVALID5,
    input  logic         RVALID6,
    output logic         RREADY0,
    output logic         RREADY1,
    output logic         RREADY2,
    output logic         RREADY3,
    output logic         RREADY4,
    output logic         RREADY5,
    output logic         RREADY6,
    output logic [W-1:0] DATA,
    output logic [2:0]   SRC,
    output logic         VALID,
    input  logic         READY,
    output logic         BUSY
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t       state, state_nx;
    logic [2:0]   ptr, ptr_nx;
    logic [2:0]   gnt, gnt_nx;
    logic [2:0]   sel;
    logic [2:0]   idx;
    logic [3:0]   sum;
    logic         found;
    logic [6:0]   req;
    logic [6:0]   rdy;
    logic [W-1:0] beat_in [7];
    logic [W-1:0] beat;
    logic         slot_free;
    logic         accept;
    logic         last;

    assign req = {RVALID6, RVALID5, RVALID4, RVALID3,
                  RVALID2, RVALID1, RVALID0};

    assign beat_in[0] = RDATA0;
    assign beat_in[1] = RDATA1;
    assign beat_in[2] = RDATA2;
    assign beat_in[3] = RDATA3;
    assign beat_in[4] = RDATA4;
    assign beat_in[5] = RDATA5;
    assign beat_in[6] = RDATA6;

    assign slot_free = !VALID || READY;

    // Scan starts one past the last served port so every requester gets a turn.
    always_comb begin
        sel   = gnt;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        if (state == IDLE) begin
            sel = '0;
            for (int i = 1; i <= 7; i++) begin
                sum = {1'b0, ptr} + 4'(i);
                idx = (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
                if (!found && req[idx]) begin
                    sel   = idx;
                    found = 1'b1;
                end
            end
        end else begin
            found = 1'b1;
        end
    end

    assign rdy    = (!RST && slot_free && found) ? (7'b1 << sel) : 7'b0;
    assign accept = |(rdy & req);
    assign beat   = beat_in[sel];
    assign last   = beat[LAST_BIT] || (PKT_LOCK == 0);

    assign RREADY0 = rdy[0];
    assign RREADY1 = rdy[1];
    assign RREADY2 = rdy[2];
    assign RREADY3 = rdy[3];
    assign RREADY4 = rdy[4];
    assign RREADY5 = rdy[5];
    assign RREADY6 = rdy[6];

    assign BUSY = (state == LOCK);

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        gnt_nx   = gnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (last) begin
                        ptr_nx = sel;
                    end else begin
                        state_nx = LOCK;
                        gnt_nx   = sel;
                    end
                end
            end
            LOCK: begin
                if (accept && last) begin
                    state_nx = IDLE;
                    ptr_nx   = gnt;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            ptr   <= 3'd6;
            gnt   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            gnt   <= gnt_nx;
        end
    end

    // Output slot: load on accept, otherwise hold until the sink drains it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            VALID <= 1'b0;
            DATA  <= '0;
            SRC   <= '0;
        end else if (accept) begin
            VALID <= 1'b1;
            DATA  <= beat;
            SRC   <= sel;
        end else if (READY) begin
            VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_net_bus_rx7_merge.sv
// Directed bench for net_bus_rx7_merge: queue-backed sources, logging sink.
// Two instances: packet-locked (A) and per-beat arbitration (B).
module tb_net_bus_rx7_merge;

    localparam int W = 4 * 9 + 14;

    logic         CLK = 1'b0;
    logic         rst_a, rst_b;
    logic         READY;
    logic [W-1:0] rdata [7];
    logic [6:0]   rvalid;
    wire  [6:0]   rready_a, rready_b;
    logic [W-1:0] data_a, data_b;
    logic [2:0]   src_a, src_b;
    logic         valid_a, valid_b, busy_a, busy_b;

    logic [W-1:0] mem [7][16];
    int           rd [7];
    int           wr [7];
    logic [6:0]   hold;
    logic         use_b;

    logic [W-1:0] log_data [64];
    logic [2:0]   log_src [64];
    int           log_cyc [64];
    int           nlog;
    int           cyc;
    int           n_tests;
    int           n_fail;

    always #5 CLK = ~CLK;

    net_bus_rx7_merge #(.DATA_WIDTH(4), .LAST_BIT(0), .PKT_LOCK(1)) dut_a (
        .CLK(CLK), .RST(rst_a),
        .RDATA0(rdata[0]), .RDATA1(rdata[1]), .RDATA2(rdata[2]),
        .RDATA3(rdata[3]), .RDATA4(rdata[4]), .RDATA5(rdata[5]),
        .RDATA6(rdata[6]),
        .RVALID0(rvalid[0]), .RVALID1(rvalid[1]), .RVALID2(rvalid[2]),
        .RVALID3(rvalid[3]), .RVALID4(rvalid[4]), .RVALID5(rvalid[5]),
        .RVALID6(rvalid[6]),
        .RREADY0(rready_a[0]), .RREADY1(rready_a[1]), .RREADY2(rready_a[2]),
        .RREADY3(rready_a[3]), .RREADY4(rready_a[4]), .RREADY5(rready_a[5]),
        .RREADY6(rready_a[6]),
        .DATA(data_a), .SRC(src_a), .VALID(valid_a), .READY(READY),
        .BUSY(busy_a)
    );

    net_bus_rx7_merge #(.DATA_WIDTH(4), .LAST_BIT(0), .PKT_LOCK(0)) dut_b (
        .CLK(CLK), .RST(rst_b),
        .RDATA0(rdata[0]), .RDATA1(rdata[1]), .RDATA2(rdata[2]),
        .RDATA3(rdata[3]), .RDATA4(rdata[4]), .RDATA5(rdata[5]),
        .RDATA6(rdata[6]),
        .RVALID0(rvalid[0]), .RVALID1(rvalid[1]), .RVALID2(rvalid[2]),
        .RVALID3(rvalid[3]), .RVALID4(rvalid[4]), .RVALID5(rvalid[5]),
        .RVALID6(rvalid[6]),
        .RREADY0(rready_b[0]), .RREADY1(rready_b[1]), .RREADY2(rready_b[2]),
        .RREADY3(rready_b[3]), .RREADY4(rready_b[4]), .RREADY5(rready_b[5]),
        .RREADY6(rready_b[6]),
        .DATA(data_b), .SRC(src_b), .VALID(valid_b), .READY(READY),
        .BUSY(busy_b)
    );

    function automatic logic [W-1:0] mk(input int p, input int k,
                                        input bit last);
        logic [W-1:0] b;
        b        = '0;
        b[0]     = last;
        b[8:1]   = k[7:0];
        b[11:9]  = p[2:0];
        b[W-1 -: 8] = 8'hA5;
        return b;
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        for (int n = 0; n < 7; n++) begin
            rvalid[n] = (rd[n] != wr[n]) && !hold[n];
            rdata[n]  = (rd[n] != wr[n]) ? mem[n][rd[n] % 16] : '0;
        end
    endtask

    task automatic push(input int p, input logic [W-1:0] b);
        mem[p][wr[p] % 16] = b;
        wr[p]++;
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_log(input int n, input int max, input string tag);
        int k;
        k = 0;
        while (nlog < n && k < max) begin
            step();
            k++;
        end
        check(tag, 64'(nlog), 64'(n));
    endtask

    // Upstream/downstream models: handshakes sampled mid-cycle, applied after the edge.
    initial begin
        logic [6:0] acc;
        forever begin
            @(negedge CLK);
            acc = rvalid & (use_b ? rready_b : rready_a);
            if (use_b ? (valid_b && READY) : (valid_a && READY)) begin
                if (nlog < 64) begin
                    log_data[nlog] = use_b ? data_b : data_a;
                    log_src[nlog]  = use_b ? src_b : src_a;
                    log_cyc[nlog]  = cyc;
                    nlog++;
                end
            end
            @(posedge CLK);
            cyc++;
            #1;
            for (int n = 0; n < 7; n++)
                if (acc[n]) rd[n]++;
            refresh();
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        nlog    = 0;
        cyc     = 0;
        hold    = '0;
        use_b   = 1'b0;
        rst_a   = 1'b1;
        rst_b   = 1'b1;
        READY   = 1'b1;
        for (int n = 0; n < 7; n++) begin
            rd[n] = 0;
            wr[n] = 0;
        end

        // Reset with every port requesting, then round-robin sweep.
        for (int n = 0; n < 7; n++) push(n, mk(n, 0, 1'b1));
        push(0, mk(0, 1, 1'b1));
        refresh();
        step();
        check("rst_rready", 64'(rready_a), 64'h0);
        step();
        check("rst_rready2", 64'(rready_a), 64'h0);
        check("rst_valid", 64'(valid_a), 64'h0);
        check("rst_data", 64'(data_a), 64'h0);
        check("rst_src", 64'(src_a), 64'h0);
        check("rst_busy", 64'(busy_a), 64'h0);
        rst_a = 1'b0;
        #1;
        check("rst_first_gnt", 64'(rready_a), 64'h01);
        nlog = 0;
        wait_log(8, 30, "rr_count");
        for (int i = 0; i < 8; i++) begin
            check("rr_src", 64'(log_src[i]), 64'(i % 7));
            check("rr_data", 64'(log_data[i]),
                  64'(mk(i % 7, (i == 7) ? 1 : 0, 1'b1)));
        end
        check("rr_back2back", 64'(log_cyc[7] - log_cyc[0]), 64'd7);

        // Packet lock: port 2 holds the grant while port 5 waits.
        nlog = 0;
        for (int j = 0; j < 4; j++) push(2, mk(2, 'h30 + j, j == 3));
        push(5, mk(5, 'h38, 1'b1));
        refresh();
        for (int s = 0; s < 5; s++) begin
            step();
            check("lock_busy", 64'(busy_a), (s < 3) ? 64'h1 : 64'h0);
            check("lock_src", 64'(src_a), (s < 4) ? 64'h2 : 64'h5);
        end
        wait_log(5, 10, "lock_count");
        check("lock_nogap", 64'(log_cyc[4] - log_cyc[0]), 64'd4);
        check("lock_last", 64'(log_data[4]), 64'(mk(5, 'h38, 1'b1)));

        // Backpressure on a port-3 packet.
        nlog = 0;
        for (int j = 0; j < 3; j++) push(3, mk(3, 'h40 + j, j == 2));
        refresh();
        step();
        check("bp_first", 64'(data_a), 64'(mk(3, 'h40, 1'b0)));
        READY = 1'b0;
        #1;
        check("bp_rready", 64'(rready_a), 64'h0);
        step();
        check("bp_hold1", 64'(data_a), 64'(mk(3, 'h40, 1'b0)));
        step();
        check("bp_hold2", 64'(data_a), 64'(mk(3, 'h40, 1'b0)));
        check("bp_src", 64'(src_a), 64'h3);
        check("bp_valid", 64'(valid_a), 64'h1);
        READY = 1'b1;
        wait_log(3, 10, "bp_count");
        for (int k = 0; k < 3; k++) step();
        check("bp_nodup", 64'(nlog), 64'd3);
        for (int j = 0; j < 3; j++)
            check("bp_order", 64'(log_data[j]), 64'(mk(3, 'h40 + j, j == 2)));

        // Bubble: granted port 1 stalls mid-packet, port 4 must wait.
        nlog = 0;
        for (int j = 0; j < 4; j++) push(1, mk(1, 'h50 + j, j == 3));
        refresh();
        step();
        push(4, mk(4, 'h58, 1'b1));
        refresh();
        step();
        hold[1] = 1'b1;
        refresh();
        #1;
        check("bub_rready", 64'(rready_a), 64'h02);
        for (int s = 0; s < 3; s++) begin
            step();
            check("bub_valid", 64'(valid_a), 64'h0);
            check("bub_busy", 64'(busy_a), 64'h1);
        end
        hold[1] = 1'b0;
        refresh();
        wait_log(5, 10, "bub_count");
        for (int j = 0; j < 5; j++)
            check("bub_src", 64'(log_src[j]), (j < 4) ? 64'h1 : 64'h4);

        // Reset in the middle of a port-6 packet.
        for (int j = 0; j < 4; j++) push(6, mk(6, 'h60 + j, j == 3));
        refresh();
        step();
        step();
        check("mid_busy", 64'(busy_a), 64'h1);
        rst_a = 1'b1;
        step();
        check("mid_rst_busy", 64'(busy_a), 64'h0);
        check("mid_rst_valid", 64'(valid_a), 64'h0);
        check("mid_rst_data", 64'(data_a), 64'h0);
        check("mid_rst_rready", 64'(rready_a), 64'h0);
        rst_a = 1'b0;
        rd[6] = wr[6];
        nlog  = 0;
        push(6, mk(6, 'h68, 1'b1));
        push(0, mk(0, 'h69, 1'b1));
        refresh();
        #1;
        check("mid_gnt0", 64'(rready_a), 64'h01);
        wait_log(2, 10, "mid_count");
        check("mid_src0", 64'(log_src[0]), 64'h0);
        check("mid_src1", 64'(log_src[1]), 64'h6);

        // Per-beat arbitration instance interleaves multi-beat packets.
        rst_a = 1'b1;
        rst_b = 1'b0;
        use_b = 1'b1;
        nlog  = 0;
        push(1, mk(1, 'h70, 1'b0));
        push(1, mk(1, 'h71, 1'b1));
        push(2, mk(2, 'h72, 1'b0));
        push(2, mk(2, 'h73, 1'b1));
        refresh();
        wait_log(4, 12, "il_count");
        check("il_d0", 64'(log_data[0]), 64'(mk(1, 'h70, 1'b0)));
        check("il_d1", 64'(log_data[1]), 64'(mk(2, 'h72, 1'b0)));
        check("il_d2", 64'(log_data[2]), 64'(mk(1, 'h71, 1'b1)));
        check("il_d3", 64'(log_data[3]), 64'(mk(2, 'h73, 1'b1)));
        check("il_src2", 64'(log_src[2]), 64'h1);
        check("il_nogap", 64'(log_cyc[3] - log_cyc[0]), 64'd3);
        check("il_busy", 64'(busy_b), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
